fli_arb: RTL

- Arbiter and sequencer that shares one float-immediate (FLI) constant ROM between two requesters:
  - Req0: the FPU execute pipeline.
  - Req1: a secondary port for the constant-preload/debug engine.
- Grants one request per cycle with valid/ready handshakes, drives the ROM index/format, and registers the NaN-boxed constant into a single-entry response register.
- Req0 has fixed priority; a starvation counter forces a grant to Req1.

---
 rtl/fli_arb_if.sv | 35 +++
 rtl/fli_arb.sv | 119 +++++++++++
 2 files changed

// File: rtl/fli_arb_if.sv
// Handshake bundle between the FLI constant arbiter, its two requesters,
// the shared constant ROM and the response consumer.
interface fli_arb_if #(
    parameter int FLEN    = 64,
    parameter int FMTBITS = 2,
    parameter int TAGW    = 5
);
    logic               Req0Valid, Req1Valid;
    logic               Req0Ready, Req1Ready;
    logic [4:0]         Req0Rs1, Req1Rs1;
    logic [FMTBITS-1:0] Req0Fmt, Req1Fmt;
    logic [TAGW-1:0]    Req0Tag, Req1Tag;
    logic [4:0]         RomRs1;
    logic [FMTBITS-1:0] RomFmt;
    logic [FLEN-1:0]    RomImm;
    logic               RspValid, RspReady;
    logic [FLEN-1:0]    RspImm;
    logic [TAGW-1:0]    RspTag;
    logic               RspSrc, RspIllegal;
    logic [31:0]        PerfGrant0, PerfGrant1;

    modport slave (
        input  Req0Valid, Req1Valid, Req0Rs1, Req1Rs1, Req0Fmt, Req1Fmt,
               Req0Tag, Req1Tag, RomImm, RspReady,
        output Req0Ready, Req1Ready, RomRs1, RomFmt, RspValid, RspImm,
               RspTag, RspSrc, RspIllegal, PerfGrant0, PerfGrant1
    );

    modport master (
        output Req0Valid, Req1Valid, Req0Rs1, Req1Rs1, Req0Fmt, Req1Fmt,
               Req0Tag, Req1Tag, RomImm, RspReady,
        input  Req0Ready, Req1Ready, RomRs1, RomFmt, RspValid, RspImm,
               RspTag, RspSrc, RspIllegal, PerfGrant0, PerfGrant1
    );
endinterface

// File: rtl/fli_arb.sv
// Two-port arbiter for the shared FLI constant ROM with a single-entry
// NaN-boxing response register. FLI_ARB_PERF_EN adds grant counters.
module fli_arb #(
    parameter int                         FLEN       = 64,
    parameter int                         FMTBITS    = 2,
    parameter int                         TAGW       = 5,
    parameter int                         STARVE_MAX = 4,
    parameter logic [(1<<FMTBITS)-1:0]    FMT_MASK   = 4'b0011
) (
    input logic        clk,
    input logic        reset,
    fli_arb_if.slave   bus
);
    localparam int WW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [WW-1:0] SMAX = WW'(STARVE_MAX);

    logic               space, promote, gnt0, gnt1, fmt_ok;
    logic [4:0]         sel_rs1;
    logic [FMTBITS-1:0] sel_fmt;
    logic [TAGW-1:0]    sel_tag;
    logic [FLEN-1:0]    boxed;

    logic               rsp_vld_q, rsp_vld_d, rsp_src_q, rsp_src_d, rsp_ill_q, rsp_ill_d;
    logic [FLEN-1:0]    rsp_imm_q, rsp_imm_d;
    logic [TAGW-1:0]    rsp_tag_q, rsp_tag_d;
    logic [WW-1:0]      wait1_q, wait1_d;

    always_comb begin
        space   = ~reset & (~rsp_vld_q | bus.RspReady);
        promote = (STARVE_MAX != 0) && bus.Req1Valid && (wait1_q >= SMAX);
        gnt1    = space & bus.Req1Valid & (promote | ~bus.Req0Valid);
        gnt0    = space & bus.Req0Valid & ~gnt1;

        sel_rs1 = gnt1 ? bus.Req1Rs1 : bus.Req0Rs1;
        sel_fmt = gnt1 ? bus.Req1Fmt : bus.Req0Fmt;
        sel_tag = gnt1 ? bus.Req1Tag : bus.Req0Tag;
        fmt_ok  = FMT_MASK[sel_fmt];

        // Narrow formats are NaN-boxed: everything above the value is forced to ones.
        boxed = bus.RomImm;
        if (sel_fmt == FMTBITS'(0)) begin
            for (int b = 32; b < FLEN; b++) boxed[b] = 1'b1;
        end else if (sel_fmt == FMTBITS'(2)) begin
            for (int b = 16; b < FLEN; b++) boxed[b] = 1'b1;
        end
    end

    always_comb begin
        rsp_vld_d = rsp_vld_q;
        rsp_imm_d = rsp_imm_q;
        rsp_tag_d = rsp_tag_q;
        rsp_src_d = rsp_src_q;
        rsp_ill_d = rsp_ill_q;
        if (gnt0 | gnt1) begin
            rsp_vld_d = 1'b1;
            rsp_imm_d = fmt_ok ? boxed : '0;
            rsp_tag_d = sel_tag;
            rsp_src_d = gnt1;
            rsp_ill_d = ~fmt_ok;
        end else if (bus.RspReady) begin
            rsp_vld_d = 1'b0;
        end

        // A stalled response register is backpressure, not lost arbitration.
        wait1_d = wait1_q;
        if (~bus.Req1Valid | gnt1)
            wait1_d = '0;
        else if (space && (wait1_q < SMAX))
            wait1_d = wait1_q + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld_q <= 1'b0;
            rsp_imm_q <= '0;
            rsp_tag_q <= '0;
            rsp_src_q <= 1'b0;
            rsp_ill_q <= 1'b0;
            wait1_q   <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_imm_q <= rsp_imm_d;
            rsp_tag_q <= rsp_tag_d;
            rsp_src_q <= rsp_src_d;
            rsp_ill_q <= rsp_ill_d;
            wait1_q   <= wait1_d;
        end
    end

`ifdef FLI_ARB_PERF_EN
    logic [31:0] perf0_q, perf1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf0_q <= '0;
            perf1_q <= '0;
        end else begin
            if (gnt0) perf0_q <= perf0_q + 32'd1;
            if (gnt1) perf1_q <= perf1_q + 32'd1;
        end
    end

    assign bus.PerfGrant0 = perf0_q;
    assign bus.PerfGrant1 = perf1_q;
`else
    assign bus.PerfGrant0 = '0;
    assign bus.PerfGrant1 = '0;
`endif

    assign bus.Req0Ready  = gnt0;
    assign bus.Req1Ready  = gnt1;
    assign bus.RomRs1     = sel_rs1;
    assign bus.RomFmt     = sel_fmt;
    assign bus.RspValid   = rsp_vld_q;
    assign bus.RspImm     = rsp_imm_q;
    assign bus.RspTag     = rsp_tag_q;
    assign bus.RspSrc     = rsp_src_q;
    assign bus.RspIllegal = rsp_ill_q;
endmodule
